// File: rtl/pcie_h2c_axis_downsizer_if.sv
// AXI-Stream bundle shared by the wide H2C side and the narrow from_net side of the downsizer.
interface pcie_h2c_axis_downsizer_if #(
  parameter int DW = 64
) ();
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/pcie_h2c_axis_downsizer.sv
// Buffers one wide XDMA H2C beat and replays it as narrow slices, low slice first, plus a packet counter.
// Optional macro PCIE_H2C_LINKDOWN_FLUSH_EN: flush the buffer and sink H2C beats while link_up is low.
module pcie_h2c_axis_downsizer #(
  parameter int S_DATA_WIDTH = 256,
  parameter int M_DATA_WIDTH = 64,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  pcie_h2c_axis_downsizer_if.slave  s_axis,
  pcie_h2c_axis_downsizer_if.master m_axis,
  output logic [CNT_WIDTH-1:0]      pkt_cnt,
  input  logic                      link_up
);
  localparam int R    = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int S_KW = S_DATA_WIDTH / 8;
  localparam int M_KW = M_DATA_WIDTH / 8;
  localparam int IDXW = (R > 1) ? $clog2(R) : 1;
  localparam int BCW  = $clog2(S_KW + 1);

  typedef enum logic {ST_EMPTY, ST_SEND} state_t;

  state_t                  state_q, state_d;
  logic [S_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [S_KW-1:0]         buf_keep_q, buf_keep_d;
  logic                    buf_last_q, buf_last_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [IDXW-1:0]         last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic [BCW-1:0]          keep_bytes;
  logic [IDXW-1:0]         load_last_idx;
  logic [M_DATA_WIDTH-1:0] slice_data [R];
  logic [M_KW-1:0]         slice_keep [R];
  logic                    at_last, s_ready, s_hs, m_hs, load_ok, flush;

  for (genvar gi = 0; gi < R; gi++) begin : g_slice
    assign slice_data[gi] = buf_data_q[gi*M_DATA_WIDTH +: M_DATA_WIDTH];
    assign slice_keep[gi] = buf_keep_q[gi*M_KW +: M_KW];
  end

`ifdef PCIE_H2C_LINKDOWN_FLUSH_EN
  assign flush = !link_up;
`else
  logic unused_link_up;
  assign unused_link_up = link_up;
  assign flush          = 1'b0;
`endif

  assign at_last       = (idx_q == last_idx_q);
  assign m_axis.tvalid = (state_q == ST_SEND);
  assign m_axis.tdata  = slice_data[idx_q];
  assign m_axis.tkeep  = slice_keep[idx_q];
  assign m_axis.tlast  = (state_q == ST_SEND) && buf_last_q && at_last;
  assign m_hs          = m_axis.tvalid && m_axis.tready;
  assign pkt_cnt       = cnt_q;

  // Refill is offered on the final slice so back-to-back beats stream without a bubble.
  always_comb begin
    s_ready = (state_q == ST_EMPTY) || (at_last && m_axis.tready);
    if (flush) begin
      s_ready = 1'b1;
    end
    if (sys_rst) begin
      s_ready = 1'b0;
    end
  end
  assign s_axis.tready = s_ready;
  assign s_hs          = s_axis.tvalid && s_ready;
  assign load_ok       = s_hs && ((|s_axis.tkeep) || s_axis.tlast);

  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < S_KW; i++) begin
      keep_bytes = keep_bytes + BCW'(s_axis.tkeep[i]);
    end
  end

  // ceil(bytes/M_KW)-1 == (bytes-1)/M_KW; an empty tlast beat still gets one slice.
  assign load_last_idx = (keep_bytes == '0) ? '0 : IDXW'((keep_bytes - 1'b1) / BCW'(M_KW));

  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_keep_d = buf_keep_q;
    buf_last_d = buf_last_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;

    if (state_q == ST_SEND && m_hs) begin
      if (at_last) begin
        state_d = ST_EMPTY;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (load_ok) begin
      state_d    = ST_SEND;
      buf_data_d = s_axis.tdata;
      buf_keep_d = s_axis.tkeep;
      buf_last_d = s_axis.tlast;
      idx_d      = '0;
      last_idx_d = load_last_idx;
    end

    if (m_hs && m_axis.tlast) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush) begin
      state_d    = ST_EMPTY;
      buf_data_d = '0;
      buf_keep_d = '0;
      buf_last_d = 1'b0;
      idx_d      = '0;
      last_idx_d = '0;
      cnt_d      = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_EMPTY;
      buf_data_q <= '0;
      buf_keep_q <= '0;
      buf_last_q <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_keep_q <= buf_keep_d;
      buf_last_q <= buf_last_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pcie_h2c_axis_downsizer.sv
// Directed + random bench for pcie_h2c_axis_downsizer with a slice scoreboard.
// Define PCIE_H2C_LINKDOWN_FLUSH_EN to also exercise the link-down flush.
module tb_pcie_h2c_axis_downsizer;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } slice_t;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        link_up;
  logic [31:0] pkt_cnt;
  logic        tready_val;
  logic        tready_rand = 1'b0;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          hs_cnt = 0;
  int          first_hs = 0;
  int          last_hs  = 0;
  logic [31:0] exp_pkt = '0;
  slice_t      exp_q[$];

  pcie_h2c_axis_downsizer_if #(.DW(256)) s_if ();
  pcie_h2c_axis_downsizer_if #(.DW(64))  m_if ();

  pcie_h2c_axis_downsizer dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .pkt_cnt (pkt_cnt),
    .link_up (link_up)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_if.tready = tready_rand ? 1'($urandom_range(0, 1)) : tready_val;
  end

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    slice_t e;
    if (!sys_rst && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      if (hs_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      hs_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_slice observed data=%h keep=%h last=%b expected=none", m_if.tdata, m_if.tkeep, m_if.tlast);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert ({m_if.tdata, m_if.tkeep, m_if.tlast} === e) else begin
          bad++;
          $error("FAIL slice observed data=%h keep=%h last=%b expected data=%h keep=%h last=%b", m_if.tdata, m_if.tkeep, m_if.tlast, e.d, e.k, e.l);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] keep_of(input int nb);
    logic [63:0] t;
    t = (64'h1 << nb) - 64'h1;
    return t[31:0];
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic push_expected(input logic [255:0] d, input logic [31:0] k, input logic l);
    int     nb;
    int     n;
    slice_t e;
    nb = 0;
    for (int i = 0; i < 32; i++) nb += int'(k[i]);
    if (nb == 0) begin
      if (l) begin
        e.d = d[63:0];
        e.k = 8'h00;
        e.l = 1'b1;
        exp_q.push_back(e);
        exp_pkt++;
      end
    end else begin
      n = (nb + 7) / 8;
      for (int i = 0; i < n; i++) begin
        e.d = d[i*64 +: 64];
        e.k = (nb - 8*i >= 8) ? 8'hFF : 8'((16'h1 << (nb - 8*i)) - 16'h1);
        e.l = l && (i == n - 1);
        exp_q.push_back(e);
      end
      if (l) exp_pkt++;
    end
  endtask

  // Returns one ns after the rising edge on which the beat was accepted.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    int to;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    push_expected(d, k, l);
    to = 0;
    @(negedge clk);
    while (s_if.tready !== 1'b1 && to < 1000) begin
      @(negedge clk);
      to++;
    end
    if (to >= 1000) chk("s_tready_timeout", 64'(to), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nbeats;
    int nb;
    int acc_cyc;
    sys_rst     = 1'b1;
    link_up     = 1'b1;
    tready_val  = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;

    #12;
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tdata", m_if.tdata, 64'd0);
    chk("rst_m_tkeep", 64'(m_if.tkeep), 64'd0);
    chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    idle(2);
    chk("idle_s_tready", 64'(s_if.tready), 64'd1);

    // Full beat: four FF slices on consecutive cycles starting one cycle after acceptance.
    hs_cnt = 0;
    send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
    acc_cyc = cyc;
    s_if.tvalid = 1'b0;
    drain(50);
    chk("full_slices", 64'(hs_cnt), 64'd4);
    chk("full_latency", 64'(first_hs), 64'(acc_cyc));
    chk("full_span", 64'(last_hs - first_hs), 64'd3);
    chk("full_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Short tail: 12 bytes -> FF then 0F, nothing after.
    hs_cnt = 0;
    send_beat(rand_data(), 32'h0000_0FFF, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    idle(5);
    chk("short_slices", 64'(hs_cnt), 64'd2);
    chk("short_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Back-to-back: 8 beats with valid held high -> 32 slices with no gaps.
    hs_cnt = 0;
    for (int b = 0; b < 8; b++) send_beat(rand_data(), 32'hFFFF_FFFF, b == 7);
    s_if.tvalid = 1'b0;
    drain(100);
    chk("b2b_slices", 64'(hs_cnt), 64'd32);
    chk("b2b_span", 64'(last_hs - first_hs), 64'd31);
    chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Empty beats: no-last is swallowed, last yields one zero-keep slice.
    hs_cnt = 0;
    send_beat(rand_data(), 32'h0, 1'b0);
    idle(5);
    chk("empty_nolast_slices", 64'(hs_cnt), 64'd0);
    send_beat(rand_data(), 32'h0, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    chk("empty_last_slices", 64'(hs_cnt), 64'd1);
    chk("empty_last_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Random packets with random backpressure and random source gaps.
    tready_rand = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      nbeats = $urandom_range(1, 3);
      for (int b = 0; b < nbeats; b++) begin
        nb = $urandom_range(0, 32);
        send_beat(rand_data(), keep_of(nb), b == nbeats - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    s_if.tvalid = 1'b0;
    drain(2000);
    tready_rand = 1'b0;
    idle(2);
    chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Reset in the middle of a stalled packet.
    tready_val = 1'b0;
    idle(2);
    send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
    idle(2);
    chk("stall_m_tvalid", 64'(m_if.tvalid), 64'd1);
    sys_rst = 1'b1;
    #1;
    exp_q.delete();
    exp_pkt = '0;
    chk("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("midrst_m_tdata", m_if.tdata, 64'd0);
    chk("midrst_m_tkeep", 64'(m_if.tkeep), 64'd0);
    chk("midrst_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("midrst_s_tready", 64'(s_if.tready), 64'd0);
    tready_val = 1'b1;
    idle(2);
    sys_rst = 1'b0;
    idle(2);
    hs_cnt = 0;
    send_beat(rand_data(), 32'h00FF_FFFF, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    chk("postrst_slices", 64'(hs_cnt), 64'd3);
    chk("postrst_pkt_cnt", 64'(pkt_cnt), 64'd1);

`ifdef PCIE_H2C_LINKDOWN_FLUSH_EN
    tready_val = 1'b0;
    idle(2);
    send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
    idle(1);
    link_up = 1'b0;
    #1;
    chk("linkdown_s_tready", 64'(s_if.tready), 64'd1);
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_pkt = 32'd1;
    chk("linkdown_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("linkdown_pkt_cnt", 64'(pkt_cnt), 64'd1);
    link_up    = 1'b1;
    tready_val = 1'b1;
    idle(2);
`endif

    // Counter wrap from a preloaded value.
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cnt_q;
    exp_pkt = 32'hFFFF_FFFE;
    chk("wrap_preload", 64'(pkt_cnt), 64'hFFFF_FFFE);
    @(posedge clk);
    #1;
    send_beat(rand_data(), 32'h0000_00FF, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    chk("wrap_max", 64'(pkt_cnt), 64'hFFFF_FFFF);
    send_beat(rand_data(), 32'h0000_FFFF, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    chk("wrap_zero", 64'(pkt_cnt), 64'd0);
    chk("wrap_model", 64'(pkt_cnt), 64'(exp_pkt));

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
